// File: rtl/plic_ctrl.sv
// Platform-level interrupt controller: per-source synchroniser, level/edge
// gateway, pending latch, priority/enable/threshold arbitration and a
// claim/complete handshake on a simple word-addressed register bus.
module plic_ctrl #(
  parameter int N_SRC       = 16,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  int_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [7:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              int_o
);

  localparam int ID_W  = 5;
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Word indices (addr_i[7:2]) of the control registers; words below N_SRC are PRIO[i].
  localparam logic [5:0] W_PENDING = 6'h10;
  localparam logic [5:0] W_ENABLE  = 6'h11;
  localparam logic [5:0] W_THRESH  = 6'h12;
  localparam logic [5:0] W_CLAIM   = 6'h13;
  localparam logic [5:0] W_MODE    = 6'h14;

  localparam logic [5:0]      N_SRC_W = 6'(N_SRC);
  localparam logic [ID_W-1:0] MAX_ID  = ID_W'(N_SRC);

  logic [N_SRC-1:0]  sync_q [SYNC_STAGES];
  logic [N_SRC-1:0]  s_prev;
  logic [N_SRC-1:0]  s;
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [N_SRC-1:0]  enable_q, mode_q, pending_q, in_service_q;
  logic [PRIO_W-1:0] thresh_q;

  logic [5:0]        word;
  logic              wr, claim, complete;
  logic [ID_W-1:0]   cid;
  logic [N_SRC-1:0]  eligible;
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [N_SRC-1:0]  claim_mask, complete_mask, set_mask;
  logic [N_SRC-1:0]  pending_d, in_service_d;
  logic [31:0]       rd;
  logic              unused;

  assign word     = addr_i[7:2];
  assign wr       = we_i & ~re_i;          // a simultaneous read takes precedence
  assign claim    = re_i & (word == W_CLAIM);
  assign complete = wr & (word == W_CLAIM);
  assign cid      = wdata_i[ID_W-1:0];
  assign s        = sync_q[SYNC_STAGES-1];
  assign unused   = &{1'b0, addr_i[1:0], wdata_i};

  // Synchroniser chain per line plus one extra flop for rising-edge detection.
  // NOTE: synchroniser flops are reset so edge detection cannot fire on stale X/garbage after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value of its predecessor.
      sync_q[0] <= int_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_prev <= s;
    end
  end

  // Arbitration: highest priority eligible source wins, ties go to the lowest index.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a variable unassigned (no latches).
    eligible  = '0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & ~in_service_q[i] & (prio_q[i] > thresh_q);
      if (eligible[i] && (best_id == '0 || prio_q[i] > best_prio)) begin
        best_id   = ID_W'(i + 1);
        best_prio = prio_q[i];
      end
    end
  end

  // Gateway next-state: claim clears, a new request sets; for edge sources the set wins.
  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    if (claim && best_id != '0) claim_mask = N_SRC'(1) << (best_id - ID_W'(1));
    if (complete && cid != '0 && cid <= MAX_ID) complete_mask = N_SRC'(1) << (cid - ID_W'(1));
    set_mask     = (mode_q & s & ~s_prev) | (~mode_q & s & ~in_service_q & ~claim_mask);
    pending_d    = (pending_q & ~claim_mask) | set_mask;
    in_service_d = (in_service_q | claim_mask) & ~complete_mask;
  end

  // Register read multiplexer; reading CLAIM returns the current winner.
  always_comb begin
    rd = '0;
    if (word < N_SRC_W) rd[PRIO_W-1:0] = prio_q[word[IDX_W-1:0]];
    case (word)
      W_PENDING: rd[N_SRC-1:0]  = pending_q;
      W_ENABLE:  rd[N_SRC-1:0]  = enable_q;
      W_THRESH:  rd[PRIO_W-1:0] = thresh_q;
      W_CLAIM:   rd[ID_W-1:0]   = best_id;
      W_MODE:    rd[N_SRC-1:0]  = mode_q;
      default:   ;
    endcase
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
      enable_q <= '0;
      thresh_q <= '0;
      mode_q   <= '0;
    end else if (wr) begin
      if (word < N_SRC_W) prio_q[word[IDX_W-1:0]] <= wdata_i[PRIO_W-1:0];
      case (word)
        W_ENABLE: enable_q <= wdata_i[N_SRC-1:0];
        W_THRESH: thresh_q <= wdata_i[PRIO_W-1:0];
        W_MODE:   mode_q   <= wdata_i[N_SRC-1:0];
        default:  ;
      endcase
    end
  end

  // Interrupt state, registered request output and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      in_service_q <= '0;
      int_o        <= 1'b0;
      rdata_o      <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      int_o        <= (best_id != '0);
      if (re_i) rdata_o <= rd;
    end
  end

endmodule

// File: tb/tb_plic_ctrl.sv
// Scoreboard bench for plic_ctrl: a transaction-level reference model predicts
// int_o every cycle and rdata_o for every read; a monitor compares.
module tb_plic_ctrl;

  localparam int N    = 16;
  localparam int PW   = 3;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  int_i;
  logic          we_i, re_i;
  logic [7:0]    addr_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic          int_o;

  plic_ctrl #(.N_SRC(N), .PRIO_W(PW), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .int_i(int_i), .we_i(we_i), .re_i(re_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int           prio_m [N];
  bit [N-1:0]   pend_m, insvc_m, en_m, mode_m;
  int           thr_m;
  bit [N-1:0]   hist [$];     // hist[j] = line values driven j+1 cycles ago
  bit           int_q [$];
  logic [31:0]  rd_q [$];
  bit [N-1:0]   irq_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) prio_m[i] = 0;
    pend_m = '0; insvc_m = '0; en_m = '0; mode_m = '0; thr_m = 0;
    hist.delete();
    for (int j = 0; j <= SYNC; j++) hist.push_back('0);
  endfunction

  function automatic bit elig(int i);
    return pend_m[i] && en_m[i] && !insvc_m[i] && (prio_m[i] > thr_m);
  endfunction

  // Highest eligible priority first, then the first source holding it.
  function automatic int model_best();
    int top = 0;
    for (int i = 0; i < N; i++) if (elig(i) && prio_m[i] > top) top = prio_m[i];
    if (top == 0) return 0;
    for (int i = 0; i < N; i++) if (elig(i) && prio_m[i] == top) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(int word, int best);
    if (word < N) return 32'(prio_m[word]);
    case (word)
      16: return 32'(pend_m);
      17: return 32'(en_m);
      18: return 32'(thr_m);
      19: return 32'(best);
      20: return 32'(mode_m);
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one clock edge with the given bus/line inputs.
  function automatic void model_step(bit we, bit re, bit [7:0] addr, bit [31:0] wd, bit [N-1:0] irq);
    int word = int'(addr[7:2]);
    int best = model_best();
    int claimed = -1;
    int cid = int'(wd[4:0]);
    bit [N-1:0] s = hist[SYNC-1];
    bit [N-1:0] sp = hist[SYNC];
    bit [N-1:0] npend = '0;
    bit wr_en = we && !re;
    int_q.push_back(best != 0);
    if (re) rd_q.push_back(model_read(word, best));
    if (re && word == 19 && best != 0) claimed = best - 1;
    for (int i = 0; i < N; i++) begin
      bit set_i;
      if (mode_m[i]) set_i = s[i] && !sp[i];
      else           set_i = s[i] && !insvc_m[i] && (i != claimed);
      npend[i] = (pend_m[i] && i != claimed) || set_i;
    end
    pend_m = npend;
    if (claimed >= 0) insvc_m[claimed] = 1'b1;
    if (wr_en) begin
      if (word < N) prio_m[word] = int'(wd[PW-1:0]);
      else case (word)
        17: en_m = wd[N-1:0];
        18: thr_m = int'(wd[PW-1:0]);
        19: if (cid >= 1 && cid <= N) insvc_m[cid-1] = 1'b0;
        20: mode_m = wd[N-1:0];
        default: ;
      endcase
    end
    hist.push_front(irq);
    void'(hist.pop_back());
  endfunction

  // Drive one cycle of stimulus (called at a falling edge) and log the prediction.
  task automatic step(input bit we, input bit re, input bit [7:0] addr, input bit [31:0] wd);
    we_i = we; re_i = re; addr_i = addr; wdata_i = wd; int_i = irq_v;
    model_step(we, re, addr, wd, irq_v);
    @(negedge clk);
  endtask

  task automatic idle(input int n = 1);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 32'h0);
  endtask
  task automatic wr(input bit [7:0] a, input bit [31:0] d); step(1'b1, 1'b0, a, d); endtask
  task automatic rd(input bit [7:0] a);                     step(1'b0, 1'b1, a, 32'h0); endtask

  // Monitor: int_o is predicted every cycle, rdata_o the cycle after each read.
  initial begin
    bit rd_seen, live;
    bit e_int;
    logic [31:0] e_rd;
    forever begin
      @(posedge clk);
      rd_seen = re_i;
      live = rst_n;
      #1;
      if (live && rst_n) begin
        if (int_q.size() == 0) check("int_o_expect_missing", 32'd1, 32'd0);
        else begin
          e_int = int_q.pop_front();
          check("int_o", {31'd0, int_o}, {31'd0, e_int});
        end
        if (rd_seen) begin
          if (rd_q.size() == 0) check("rdata_expect_missing", 32'd1, 32'd0);
          else begin
            e_rd = rd_q.pop_front();
            check("rdata_o", rdata_o, e_rd);
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op, id;
    rst_n = 1'b0; we_i = 1'b0; re_i = 1'b0; addr_i = '0; wdata_i = '0; int_i = '0; irq_v = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Level source 3: latency, claim, drop of int_o.
    wr(8'h0C, 32'd2); wr(8'h44, 32'h0008);
    irq_v[3] = 1'b1;
    idle(3);
    rd(8'h4C);
    idle(1);
    irq_v[3] = 1'b0;
    idle(3);
    wr(8'h4C, 32'd4);

    // Priority order and tie-break.
    wr(8'h04, 32'd5); wr(8'h18, 32'd5); wr(8'h24, 32'd7);
    wr(8'h44, 32'h0242);
    irq_v[1] = 1'b1; irq_v[6] = 1'b1; irq_v[9] = 1'b1;
    idle(4);
    irq_v[1] = 1'b0; irq_v[6] = 1'b0; irq_v[9] = 1'b0;
    idle(2);
    rd(8'h4C); wr(8'h4C, 32'd10);
    rd(8'h4C); wr(8'h4C, 32'd2);
    rd(8'h4C); wr(8'h4C, 32'd7);
    idle(1);

    // Threshold gating.
    wr(8'h48, 32'd3); wr(8'h00, 32'd3); wr(8'h44, 32'h0001);
    irq_v[0] = 1'b1;
    idle(5);
    wr(8'h48, 32'd2);
    idle(3);
    rd(8'h4C);
    irq_v[0] = 1'b0;
    idle(3);
    wr(8'h4C, 32'd1);

    // Edge source 5: coalescing and set-wins-over-claim.
    wr(8'h50, 32'h0020); wr(8'h14, 32'd4); wr(8'h44, 32'h0020); wr(8'h48, 32'd0);
    irq_v[5] = 1'b1; idle(1); irq_v[5] = 1'b0; idle(4);
    rd(8'h4C);
    irq_v[5] = 1'b1; idle(1); irq_v[5] = 1'b0; idle(4);
    rd(8'h40); idle(1);
    wr(8'h4C, 32'd6); idle(2);
    irq_v[5] = 1'b1; idle(1); irq_v[5] = 1'b0; idle(1);
    rd(8'h4C);
    rd(8'h40); idle(1);

    // Level source 2 held high: re-pend after complete; bogus complete ignored.
    wr(8'h50, 32'h0000); wr(8'h08, 32'd6); wr(8'h44, 32'h0024);
    irq_v[2] = 1'b1;
    idle(4);
    rd(8'h4C); wr(8'h4C, 32'd3);
    idle(3);
    rd(8'h4C); wr(8'h4C, 32'd9);
    rd(8'h40); idle(1);

    // Asynchronous reset with state live: outputs clear without a clock edge.
    rst_n = 1'b0;
    #1;
    check("async_rst_int_o", {31'd0, int_o}, 32'd0);
    check("async_rst_rdata_o", rdata_o, 32'd0);
    int_q.delete(); rd_q.delete();
    int_i = irq_v; we_i = 1'b0; re_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd(8'h40); idle(2); rd(8'h40); rd(8'h44); rd(8'h00);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) irq_v[$urandom_range(0, N-1)] ^= 1'b1;
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2: idle(1);
        3, 4:    rd(8'h4C);
        5: begin
          id = 0;
          if ($urandom_range(0, 1) != 0) id = $urandom_range(0, 20);
          else for (int i = 0; i < N; i++) if (insvc_m[i]) id = i + 1;
          wr(8'h4C, 32'(id));
        end
        6:  wr({$urandom_range(16, 20), 2'b00}, $urandom);
        7:  wr({$urandom_range(0, 15), 2'b00}, $urandom);
        8:  rd(8'($urandom));
        9:  step(1'b1, 1'b1, 8'($urandom), $urandom);
        10: wr(8'h48, 32'($urandom_range(0, 2)));
        default: wr(8'($urandom), $urandom);
      endcase
    end
    idle(2);

    check("int_queue_drained", 32'(int_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
